// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one slave port, grant held for the whole cyc tenure,
// with a watchdog that aborts transfers the slave never answers.
module wb_rr_arbiter #(
    parameter int N_MASTER = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_MASTER-1:0]    m_cyc_i,
    input  logic [N_MASTER-1:0]    m_stb_i,
    input  logic [N_MASTER-1:0]    m_we_i,
    input  logic [N_MASTER*4-1:0]  m_sel_i,
    input  logic [N_MASTER*32-1:0] m_adr_i,
    input  logic [N_MASTER*32-1:0] m_dat_i,
    output logic [N_MASTER-1:0]    m_ack_o,
    output logic [N_MASTER-1:0]    m_err_o,
    output logic [31:0]            m_dat_o,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    output logic                   s_we_o,
    output logic [3:0]             s_sel_o,
    output logic [31:0]            s_adr_o,
    output logic [31:0]            s_dat_o,
    input  logic [31:0]            s_dat_i,
    input  logic                   s_ack_i,
    input  logic                   s_err_i,
    output logic [N_MASTER-1:0]    gnt_o,
    output logic                   busy_o
);

    localparam int LW = $clog2(N_MASTER);
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] TMO      = WW'(TIMEOUT);
    localparam logic [LW-1:0] LAST_RST = LW'(N_MASTER - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN,
        ST_ABORT
    } state_t;

    state_t                r_state, w_stateNext;
    logic [N_MASTER-1:0]   r_gnt, w_gntNext, w_pickOh;
    logic [LW-1:0]         r_last, w_lastNext, w_pickIdx;
    logic                  w_pickValid;
    logic [WW-1:0]         r_wdt, w_wdtNext;
    logic                  w_gCyc, w_gStb, w_gWe;
    logic [3:0]            w_gSel;
    logic [31:0]           w_gAdr, w_gDat;
    logic                  w_resp, w_expire;

    // Later offsets are visited first so the nearest requester after r_last overwrites them.
    always_comb begin
        w_pickValid = 1'b0;
        w_pickIdx   = '0;
        w_pickOh    = '0;
        for (int off = N_MASTER; off >= 1; off--) begin
            for (int j = 0; j < N_MASTER; j++) begin
                if (m_cyc_i[j] && (j == (int'(r_last) + off) % N_MASTER)) begin
                    w_pickValid = 1'b1;
                    w_pickIdx   = LW'(j);
                    w_pickOh    = '0;
                    w_pickOh[j] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_gCyc = 1'b0;
        w_gStb = 1'b0;
        w_gWe  = 1'b0;
        w_gSel = '0;
        w_gAdr = '0;
        w_gDat = '0;
        for (int k = 0; k < N_MASTER; k++) begin
            if (r_gnt[k]) begin
                w_gCyc = m_cyc_i[k];
                w_gStb = m_stb_i[k];
                w_gWe  = m_we_i[k];
                w_gSel = m_sel_i[k*4 +: 4];
                w_gAdr = m_adr_i[k*32 +: 32];
                w_gDat = m_dat_i[k*32 +: 32];
            end
        end
    end

    assign w_resp   = s_ack_i | s_err_i;
    assign w_expire = (TIMEOUT != 0) && (r_state == ST_OWN) && w_gCyc && w_gStb &&
                      !w_resp && (r_wdt == TMO);

    // A response in the expiry cycle wins because w_expire already requires !w_resp.
    always_comb begin
        w_stateNext = r_state;
        w_gntNext   = r_gnt;
        w_lastNext  = r_last;
        w_wdtNext   = '0;
        s_cyc_o     = 1'b0;
        s_stb_o     = 1'b0;
        s_we_o      = 1'b0;
        s_sel_o     = '0;
        s_adr_o     = '0;
        s_dat_o     = '0;
        m_ack_o     = '0;
        m_err_o     = '0;
        m_dat_o     = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pickValid) begin
                    w_stateNext = ST_OWN;
                    w_gntNext   = w_pickOh;
                    w_lastNext  = w_pickIdx;
                end
            end
            ST_OWN: begin
                s_cyc_o = w_gCyc;
                s_stb_o = w_gStb;
                s_we_o  = w_gWe;
                s_sel_o = w_gSel;
                s_adr_o = w_gAdr;
                s_dat_o = w_gDat;
                m_ack_o = r_gnt & {N_MASTER{s_ack_i}};
                m_err_o = r_gnt & {N_MASTER{s_err_i | w_expire}};
                m_dat_o = s_dat_i;
                w_wdtNext = r_wdt;
                if (w_resp) begin
                    w_wdtNext = '0;
                end else if (w_gStb && (r_wdt != {WW{1'b1}})) begin
                    w_wdtNext = r_wdt + WW'(1);
                end
                if (!w_gCyc) begin
                    w_stateNext = ST_IDLE;
                    w_gntNext   = '0;
                end else if (w_expire) begin
                    w_stateNext = ST_ABORT;
                end
            end
            ST_ABORT: begin
                if (!w_gCyc) begin
                    w_stateNext = ST_IDLE;
                    w_gntNext   = '0;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
                w_gntNext   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_last  <= LAST_RST;
            r_wdt   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_gnt   <= w_gntNext;
            r_last  <= w_lastNext;
            r_wdt   <= w_wdtNext;
        end
    end

    assign gnt_o  = r_gnt;
    assign busy_o = (r_state != ST_IDLE);

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter (2 masters, TIMEOUT=4) with hand-computed per-cycle expectations.
module tb_wb_rr_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  m_cyc_i, m_stb_i, m_we_i;
    logic [7:0]  m_sel_i;
    logic [63:0] m_adr_i, m_dat_i;
    logic [1:0]  m_ack_o, m_err_o;
    logic [31:0] m_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i, s_err_i;
    logic [1:0]  gnt_o;
    logic        busy_o;

    int nCompared   = 0;
    int nMismatched = 0;

    wb_rr_arbiter #(.N_MASTER(2), .TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_sel_i(m_sel_i), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .gnt_o(gnt_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic m, input logic cyc, input logic stb, input logic we,
                                 input logic [31:0] adr, input logic [31:0] dat);
        m_cyc_i[m] = cyc;
        m_stb_i[m] = stb;
        m_we_i[m]  = we;
        if (m == 1'b0) begin
            m_adr_i[31:0] = adr;
            m_dat_i[31:0] = dat;
        end else begin
            m_adr_i[63:32] = adr;
            m_dat_i[63:32] = dat;
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL time limit: got expired, expected finish");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        rst_i   = 1'b1;
        m_cyc_i = '0;
        m_stb_i = '0;
        m_we_i  = '0;
        m_sel_i = {4'h3, 4'hF};
        m_adr_i = '0;
        m_dat_i = '0;
        s_dat_i = '0;
        s_ack_i = 1'b0;
        s_err_i = 1'b0;

        tick(); tick(); settle();
        checkOutput("reset gnt", 64'(gnt_o), 64'd0);
        checkOutput("reset busy", 64'(busy_o), 64'd0);
        checkOutput("reset s_cyc", 64'(s_cyc_o), 64'd0);

        tick(); rst_i = 1'b0; s_ack_i = 1'b1; settle();
        checkOutput("idle ack ignored", 64'(m_ack_o), 64'd0);

        // Single read by master 1, acked two cycles after grant.
        tick(); s_ack_i = 1'b0; applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h14, 32'h0); settle();
        checkOutput("t1 no grant yet", 64'(gnt_o), 64'd0);
        tick(); settle();
        checkOutput("t1 gnt", 64'(gnt_o), 64'h2);
        checkOutput("t1 busy", 64'(busy_o), 64'd1);
        checkOutput("t1 s_cyc", 64'(s_cyc_o), 64'd1);
        checkOutput("t1 s_adr", 64'(s_adr_o), 64'h14);
        checkOutput("t1 s_sel", 64'(s_sel_o), 64'h3);
        checkOutput("t1 s_we", 64'(s_we_o), 64'd0);
        checkOutput("t1 wait ack", 64'(m_ack_o), 64'd0);
        tick(); settle();
        checkOutput("t1 wait ack 2", 64'(m_ack_o), 64'd0);
        tick(); s_ack_i = 1'b1; s_dat_i = 32'hDEADBEEF; settle();
        checkOutput("t1 ack", 64'(m_ack_o), 64'h2);
        checkOutput("t1 rdata", 64'(m_dat_o), 64'hDEADBEEF);
        tick(); s_ack_i = 1'b0; applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); settle();
        checkOutput("t1 release gnt held", 64'(gnt_o), 64'h2);
        checkOutput("t1 release s_cyc", 64'(s_cyc_o), 64'd0);
        tick(); settle();
        checkOutput("t1 idle gnt", 64'(gnt_o), 64'd0);
        checkOutput("t1 idle busy", 64'(busy_o), 64'd0);

        // Both masters request together; master 0 first, one idle cycle, then master 1.
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 32'h11);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h200, 32'h22);
        settle();
        tick(); s_ack_i = 1'b1; settle();
        checkOutput("t2 gnt m0", 64'(gnt_o), 64'h1);
        checkOutput("t2 adr m0", 64'(s_adr_o), 64'h100);
        checkOutput("t2 dat m0", 64'(s_dat_o), 64'h11);
        checkOutput("t2 ack m0", 64'(m_ack_o), 64'h1);
        tick(); s_ack_i = 1'b0; applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); settle();
        checkOutput("t2 m0 drop gnt", 64'(gnt_o), 64'h1);
        checkOutput("t2 m1 stalled", 64'(m_ack_o), 64'd0);
        tick(); settle();
        checkOutput("t2 idle gap", 64'(gnt_o), 64'd0);
        tick(); s_ack_i = 1'b1; settle();
        checkOutput("t2 gnt m1", 64'(gnt_o), 64'h2);
        checkOutput("t2 adr m1", 64'(s_adr_o), 64'h200);
        checkOutput("t2 ack m1", 64'(m_ack_o), 64'h2);
        tick(); s_ack_i = 1'b0; applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); settle();
        tick(); settle();
        checkOutput("t2 end busy", 64'(busy_o), 64'd0);

        // Master 0 bursts four writes while master 1 waits.
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'hA0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
        settle();
        for (int i = 0; i < 4; i++) begin
            tick(); applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'(4 * i), 32'(32'hA0 + i)); s_ack_i = 1'b1; settle();
            checkOutput("t3 burst gnt", 64'(gnt_o), 64'h1);
            checkOutput("t3 burst adr", 64'(s_adr_o), 64'(4 * i));
            checkOutput("t3 burst stb", 64'(s_stb_o), 64'd1);
            checkOutput("t3 burst ack", 64'(m_ack_o), 64'h1);
        end
        tick(); s_ack_i = 1'b0; applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); settle();
        checkOutput("t3 drop gnt", 64'(gnt_o), 64'h1);
        tick(); settle();
        checkOutput("t3 idle gap", 64'(gnt_o), 64'd0);
        tick(); s_ack_i = 1'b1; settle();
        checkOutput("t3 gnt m1", 64'(gnt_o), 64'h2);
        checkOutput("t3 adr m1", 64'(s_adr_o), 64'h300);
        checkOutput("t3 ack m1", 64'(m_ack_o), 64'h2);
        tick(); s_ack_i = 1'b0; applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); settle();
        tick(); settle();

        // Watchdog: error in the fifth strobed cycle, then ABORT until cyc drops.
        tick(); applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0); settle();
        tick(); settle();
        checkOutput("t4 gnt", 64'(gnt_o), 64'h1);
        checkOutput("t4 stb", 64'(s_stb_o), 64'd1);
        for (int i = 1; i < 4; i++) begin
            tick(); settle();
            checkOutput("t4 no early err", 64'(m_err_o), 64'd0);
        end
        tick(); settle();
        checkOutput("t4 err pulse", 64'(m_err_o), 64'h1);
        checkOutput("t4 err cycle s_cyc", 64'(s_cyc_o), 64'd1);
        tick(); s_ack_i = 1'b1; settle();
        checkOutput("t4 err single", 64'(m_err_o), 64'd0);
        checkOutput("t4 abort s_cyc", 64'(s_cyc_o), 64'd0);
        checkOutput("t4 late ack dropped", 64'(m_ack_o), 64'd0);
        checkOutput("t4 abort busy", 64'(busy_o), 64'd1);
        checkOutput("t4 abort gnt", 64'(gnt_o), 64'h1);
        tick(); s_ack_i = 1'b0; applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); settle();
        checkOutput("t4 abort until edge", 64'(busy_o), 64'd1);
        tick(); settle();
        checkOutput("t4 released", 64'(gnt_o), 64'd0);

        // Ack arriving exactly in the expiry cycle wins.
        tick(); applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h50, 32'h0); settle();
        tick(); settle();
        for (int i = 1; i < 4; i++) begin
            tick(); settle();
        end
        tick(); s_ack_i = 1'b1; s_dat_i = 32'h1234; settle();
        checkOutput("t5 ack on expiry", 64'(m_ack_o), 64'h1);
        checkOutput("t5 no err", 64'(m_err_o), 64'd0);
        checkOutput("t5 rdata", 64'(m_dat_o), 64'h1234);
        tick(); s_ack_i = 1'b0; settle();
        checkOutput("t5 no abort s_cyc", 64'(s_cyc_o), 64'd1);
        checkOutput("t5 no late err", 64'(m_err_o), 64'd0);
        tick(); applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); settle();
        tick(); settle();
        checkOutput("t5 end busy", 64'(busy_o), 64'd0);

        // Reset mid-tenure of master 1; master 0 wins afterwards.
        tick(); applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h60, 32'h66); settle();
        tick(); settle();
        checkOutput("t6 gnt m1", 64'(gnt_o), 64'h2);
        tick(); rst_i = 1'b1; settle();
        tick(); rst_i = 1'b0; applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h70, 32'h0); settle();
        checkOutput("t6 reset gnt", 64'(gnt_o), 64'd0);
        checkOutput("t6 reset s_cyc", 64'(s_cyc_o), 64'd0);
        checkOutput("t6 reset busy", 64'(busy_o), 64'd0);
        tick(); settle();
        checkOutput("t6 gnt m0", 64'(gnt_o), 64'h1);
        checkOutput("t6 adr m0", 64'(s_adr_o), 64'h70);

        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
